// File: rtl/axis_frame_generator_if.sv
// AXI4-Stream beat interface between the frame generator and its downstream sink.
// The generator owns tdata/tvalid/tlast; the sink owns tready.
interface axis_frame_generator_if #(
  parameter int DATA_W = 128
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_frame_generator.sv
// AXI4-Stream test-vector source for the PFB/FFT chain: whole FFT_LEN-sample frames
// of impulse, ramp, DC or Nyquist samples, SAMP_PER_CLK complex samples per beat.
module axis_frame_generator #(
  parameter int WIDTH        = 16,
  parameter int SAMP_PER_CLK = 4,
  parameter int FFT_LEN      = 16,
  parameter int IMPULSE_PHA  = 0,
  parameter int IMPULSE_VAL  = 1,
  parameter int NUM_FRAMES   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_en,
  input  logic [1:0]                    i_mode,
  axis_frame_generator_if.master        m_axis,
  output logic [31:0]                   o_frame_cnt,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int BEATS = FFT_LEN / SAMP_PER_CLK;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = SAMP_PER_CLK * 2 * WIDTH;

  localparam logic [BW-1:0]    LAST_BEAT   = BW'(BEATS - 1);
  localparam logic [WIDTH-1:0] POS_VAL     = WIDTH'(IMPULSE_VAL);
  localparam logic [WIDTH-1:0] NEG_VAL     = WIDTH'(-IMPULSE_VAL);
  localparam logic [31:0]      FRAME_LIMIT = 32'(NUM_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {M_IMPULSE, M_RAMP, M_DC, M_NYQUIST} mode_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [BW-1:0]     r_beat;
  logic [BW-1:0]     w_beat_nxt;
  mode_t             r_mode;
  mode_t             w_mode_nxt;
  logic [31:0]       r_frame_cnt;
  logic [31:0]       w_frame_cnt_nxt;
  logic [DW-1:0]     r_tdata;
  logic [DW-1:0]     w_tdata_nxt;
  logic              r_tvalid;
  logic              w_tvalid_nxt;
  logic              r_tlast;
  logic              w_tlast_nxt;
  logic              r_busy;
  logic              r_done;
  logic              w_load;
  logic              w_step;

  logic              w_hs;
  logic              w_last_beat;
  logic              w_frame_end;
  logic [31:0]       w_cnt_inc;

  assign w_hs        = r_tvalid & m_axis.tready;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_frame_end = w_hs & w_last_beat;
  assign w_cnt_inc   = r_frame_cnt + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // en is only honoured in IDLE and on the tlast handshake, so frames are never cut short.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_frame_end) begin
          if ((NUM_FRAMES != 0) && (w_cnt_inc == FRAME_LIMIT)) begin
            w_next_state = S_DONE;
          end else if (!i_en) begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (!i_en) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_load          = ((r_state == S_IDLE) && i_en) ||
                      (w_frame_end && (w_next_state == S_RUN));
    w_step          = w_hs && !w_last_beat;
    w_beat_nxt      = r_beat;
    w_mode_nxt      = r_mode;
    w_frame_cnt_nxt = r_frame_cnt;
    if (w_load) begin
      w_beat_nxt = '0;
      w_mode_nxt = mode_t'(i_mode);
    end else if (w_step) begin
      w_beat_nxt = r_beat + 1'b1;
    end
    if ((r_state == S_IDLE) && i_en) begin
      w_frame_cnt_nxt = '0;
    end else if (w_frame_end) begin
      w_frame_cnt_nxt = w_cnt_inc;
    end
    w_tvalid_nxt = (w_next_state == S_RUN);
    w_tlast_nxt  = w_tvalid_nxt && (w_beat_nxt == LAST_BEAT);
  end

  // Sample pattern for the beat about to be presented; lane k carries n = beat*SAMP_PER_CLK + k.
  always_comb begin
    int               n;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    w_tdata_nxt = '0;
    for (int k = 0; k < SAMP_PER_CLK; k++) begin
      n  = int'(w_beat_nxt) * SAMP_PER_CLK + k;
      re = '0;
      im = '0;
      case (w_mode_nxt)
        M_IMPULSE: re = (n == IMPULSE_PHA) ? POS_VAL : '0;
        M_RAMP: begin
          re = WIDTH'(n);
          im = WIDTH'(-n);
        end
        M_DC:      re = POS_VAL;
        M_NYQUIST: re = n[0] ? NEG_VAL : POS_VAL;
        default:   re = '0;
      endcase
      w_tdata_nxt[k*2*WIDTH +: 2*WIDTH] = {im, re};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat      <= '0;
      r_mode      <= M_IMPULSE;
      r_frame_cnt <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_beat      <= w_beat_nxt;
      r_mode      <= w_mode_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_tvalid    <= w_tvalid_nxt;
      r_tlast     <= w_tlast_nxt;
      r_busy      <= (w_next_state == S_RUN);
      r_done      <= (w_next_state == S_DONE);
      if (w_load || w_step) begin
        r_tdata <= w_tdata_nxt;
      end
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_axis_frame_generator.sv
// Bench for axis_frame_generator: two instances (continuous and two-frame limited) checked
// every cycle against a frame-level reference model of the emitted stream.
module tb_axis_frame_generator;

  localparam int DW      = 128;
  localparam int BEATS   = 4;
  localparam int SPC     = 4;
  localparam int PHA     = 3;
  localparam int VAL_A   = 16;
  localparam int VAL_B   = 5;
  localparam int NF_A    = 0;
  localparam int NF_B    = 2;
  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstIn   [2];
  logic       enIn    [2];
  logic [1:0] modeIn  [2];
  logic       readyIn [2];

  axis_frame_generator_if #(.DATA_W(DW)) ifA ();
  axis_frame_generator_if #(.DATA_W(DW)) ifB ();
  assign ifA.tready = readyIn[0];
  assign ifB.tready = readyIn[1];

  wire [31:0] cntA, cntB;
  wire        busyA, busyB, doneA, doneB;

  axis_frame_generator #(
    .WIDTH(16), .SAMP_PER_CLK(SPC), .FFT_LEN(16),
    .IMPULSE_PHA(PHA), .IMPULSE_VAL(VAL_A), .NUM_FRAMES(NF_A)
  ) dutA (
    .clk(clk), .rst_n(rstIn[0]), .i_en(enIn[0]), .i_mode(modeIn[0]),
    .m_axis(ifA), .o_frame_cnt(cntA), .o_busy(busyA), .o_done(doneA)
  );

  axis_frame_generator #(
    .WIDTH(16), .SAMP_PER_CLK(SPC), .FFT_LEN(16),
    .IMPULSE_PHA(PHA), .IMPULSE_VAL(VAL_B), .NUM_FRAMES(NF_B)
  ) dutB (
    .clk(clk), .rst_n(rstIn[1]), .i_en(enIn[1]), .i_mode(modeIn[1]),
    .m_axis(ifB), .o_frame_cnt(cntB), .o_busy(busyB), .o_done(doneB)
  );

  wire [DW-1:0] obsTdata [2];
  wire          obsValid [2];
  wire          obsLast  [2];
  wire [31:0]   obsCnt   [2];
  wire          obsBusy  [2];
  wire          obsDone  [2];
  assign obsTdata[0] = ifA.tdata;  assign obsTdata[1] = ifB.tdata;
  assign obsValid[0] = ifA.tvalid; assign obsValid[1] = ifB.tvalid;
  assign obsLast[0]  = ifA.tlast;  assign obsLast[1]  = ifB.tlast;
  assign obsCnt[0]   = cntA;       assign obsCnt[1]   = cntB;
  assign obsBusy[0]  = busyA;      assign obsBusy[1]  = busyB;
  assign obsDone[0]  = doneA;      assign obsDone[1]  = doneB;

  int          mState   [2];
  int          mBeat    [2];
  int          mMode    [2];
  logic [31:0] mFrames  [2];
  bit          mInReset [2];
  int          checks = 0;
  int          errors = 0;

  // Whole beat computed straight from the sample formulas, 32-bit lane = {im, re}.
  function automatic logic [DW-1:0] expBeat(int m, int beat, int val);
    logic [DW-1:0] r;
    int n, re, im;
    r = '0;
    for (int k = 0; k < SPC; k++) begin
      n  = beat * SPC + k;
      re = 0;
      im = 0;
      case (m)
        0: re = (n == PHA) ? val : 0;
        1: begin re = n; im = -n; end
        2: re = val;
        default: re = ((n % 2) == 0) ? val : -val;
      endcase
      r[k*32 +: 32] = {im[15:0], re[15:0]};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input int d);
    int nf;
    nf = (d == 0) ? NF_A : NF_B;
    mInReset[d] = !rstIn[d];
    if (!rstIn[d]) begin
      mState[d]  = ST_IDLE;
      mBeat[d]   = 0;
      mFrames[d] = '0;
    end else if (mState[d] == ST_IDLE) begin
      if (enIn[d]) begin
        mState[d]  = ST_RUN;
        mBeat[d]   = 0;
        mMode[d]   = int'(modeIn[d]);
        mFrames[d] = '0;
      end
    end else if (mState[d] == ST_RUN) begin
      if (readyIn[d]) begin
        if (mBeat[d] == BEATS - 1) begin
          mFrames[d] = mFrames[d] + 32'd1;
          if (nf != 0 && mFrames[d] == 32'(nf)) mState[d] = ST_DONE;
          else if (!enIn[d])                    mState[d] = ST_IDLE;
          else begin
            mBeat[d] = 0;
            mMode[d] = int'(modeIn[d]);
          end
        end else begin
          mBeat[d] = mBeat[d] + 1;
        end
      end
    end else if (!enIn[d]) begin
      mState[d] = ST_IDLE;
    end
  endtask

  task automatic checkOutput(input int d);
    string p;
    int    val;
    p   = (d == 0) ? "A" : "B";
    val = (d == 0) ? VAL_A : VAL_B;
    check({p, ".tvalid"},    DW'(obsValid[d]), DW'(mState[d] == ST_RUN));
    check({p, ".busy"},      DW'(obsBusy[d]),  DW'(mState[d] == ST_RUN));
    check({p, ".done"},      DW'(obsDone[d]),  DW'(mState[d] == ST_DONE));
    check({p, ".frame_cnt"}, DW'(obsCnt[d]),   DW'(mFrames[d]));
    if (mState[d] == ST_RUN) begin
      check({p, ".tdata"}, obsTdata[d], expBeat(mMode[d], mBeat[d], val));
      check({p, ".tlast"}, DW'(obsLast[d]), DW'(mBeat[d] == BEATS - 1));
    end else begin
      check({p, ".tlast_idle"}, DW'(obsLast[d]), '0);
    end
    if (mInReset[d]) begin
      check({p, ".tdata_reset"}, obsTdata[d], '0);
    end
  endtask

  task automatic applyStimulus(input int d, input bit rstn, input bit en, input int mode, input bit ready);
    rstIn[d]   = rstn;
    enIn[d]    = en;
    modeIn[d]  = 2'(mode);
    readyIn[d] = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) modelStep(d);
    for (int d = 0; d < 2; d++) checkOutput(d);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic waitIdle(input int d, input int maxCyc);
    int i;
    i = 0;
    while ((obsValid[d] !== 1'b0 || obsBusy[d] !== 1'b0) && i < maxCyc) begin
      tick();
      i++;
    end
    checks++;
    assert (i < maxCyc) else begin
      errors++;
      $error("[TB] FAIL wait_idle dut%0d observed=timeout required=idle within %0d cycles", d, maxCyc);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mState[d] = ST_IDLE; mBeat[d] = 0; mMode[d] = 0; mFrames[d] = '0; mInReset[d] = 1'b1;
      applyStimulus(d, 1'b0, 1'b0, 0, 1'b1);
    end
    runCycles(2);

    $display("[TB] impulse mode, continuous back-to-back frames");
    applyStimulus(1, 1'b1, 1'b0, 0, 1'b1);
    applyStimulus(0, 1'b1, 1'b1, 0, 1'b1);
    tick();
    check("A.impulse_beat0", obsTdata[0], 128'h00000010_00000000_00000000_00000000);
    runCycles(8);
    check("A.two_frames", DW'(obsCnt[0]), DW'(2));

    $display("[TB] Nyquist frame, mode switched to DC mid-frame");
    modeIn[0] = 2'd3;
    runCycles(4);
    check("A.nyquist_beat0", obsTdata[0], 128'h0000FFF0_00000010_0000FFF0_00000010);
    tick();
    modeIn[0] = 2'd2;
    runCycles(2);
    check("A.nyquist_beat3", obsTdata[0], 128'h0000FFF0_00000010_0000FFF0_00000010);
    tick();
    check("A.dc_next_frame", obsTdata[0], 128'h00000010_00000010_00000010_00000010);

    $display("[TB] ramp with random backpressure, then random modes");
    modeIn[0] = 2'd1;
    for (int i = 0; i < 60; i++) begin
      readyIn[0] = 1'($urandom_range(0, 1));
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      readyIn[0] = 1'($urandom_range(0, 1));
      modeIn[0]  = 2'($urandom_range(0, 3));
      tick();
    end

    $display("[TB] en dropped at beat 1");
    applyStimulus(0, 1'b1, 1'b0, 1, 1'b1);
    waitIdle(0, 50);
    applyStimulus(0, 1'b1, 1'b1, 1, 1'b1);
    runCycles(2);
    enIn[0] = 1'b0;
    runCycles(2);
    check("A.tlast_beat3", DW'(obsLast[0]), DW'(1));
    tick();
    check("A.idle_after_drop", DW'(obsValid[0]), '0);
    check("A.cnt_after_drop", DW'(obsCnt[0]), DW'(1));

    $display("[TB] reset mid-frame under backpressure");
    applyStimulus(0, 1'b1, 1'b1, 1, 1'b1);
    runCycles(3);
    applyStimulus(0, 1'b0, 1'b1, 1, 1'b0);
    tick();
    check("A.reset_tvalid", DW'(obsValid[0]), '0);
    check("A.reset_cnt", DW'(obsCnt[0]), '0);
    applyStimulus(0, 1'b1, 1'b1, 1, 1'b1);
    tick();
    check("A.restart_ramp_beat0", obsTdata[0], 128'hFFFD0003_FFFE0002_FFFF0001_00000000);
    enIn[0] = 1'b0;
    waitIdle(0, 50);

    $display("[TB] frame-limited instance");
    applyStimulus(1, 1'b1, 1'b1, 1, 1'b1);
    runCycles(9);
    check("B.done", DW'(obsDone[1]), DW'(1));
    check("B.cnt_limit", DW'(obsCnt[1]), DW'(2));
    check("B.tvalid_done", DW'(obsValid[1]), '0);
    enIn[1] = 1'b0;
    tick();
    applyStimulus(1, 1'b1, 1'b1, 3, 1'b1);
    tick();
    check("B.nyquist_beat0", obsTdata[1], 128'h0000FFFB_00000005_0000FFFB_00000005);
    begin
      int i;
      i = 0;
      while (obsDone[1] !== 1'b1 && i < 200) begin
        readyIn[1] = 1'($urandom_range(0, 1));
        tick();
        i++;
      end
      checks++;
      assert (i < 200) else begin
        errors++;
        $error("[TB] FAIL wait_done observed=timeout required=done within 200 cycles");
      end
    end
    enIn[1] = 1'b0;
    runCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
